// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter driving a registered 2:1 data mux, with a
// per-owner burst limit. Define MUX_RR_ARBITER_STATS_EN to add per-side transfer counters.
module mux_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             select,
  output logic [WIDTH-1:0] s,
  output logic             s_valid
`ifdef MUX_RR_ARBITER_STATS_EN
  ,
  output logic [7:0]       cnt_a,
  output logic [7:0]       cnt_b
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  localparam logic [3:0] HOLD = 4'(HOLD_MAX);

  state_t           state, state_nxt;
  logic             last;        // 0 = A owned most recently, 1 = B
  logic [3:0]       burst;
  logic [3:0]       burst_inc;
  logic             xfer_a, xfer_b, xfer;
  logic             hold_hit;
  logic             enter_own;
  logic [WIDTH-1:0] mux_data;

  assign xfer_a    = (state == OWN_A) && req_a;
  assign xfer_b    = (state == OWN_B) && req_b;
  assign xfer      = xfer_a || xfer_b;
  assign burst_inc = (burst >= HOLD) ? HOLD : burst + 4'd1;
  // The transfer that brings the burst to HOLD_MAX is the owner's last one if the other side waits.
  assign hold_hit  = xfer && (burst_inc == HOLD);
  assign enter_own = (state_nxt != state) && (state_nxt != IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment at the top keeps this combinational block latch-free.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_a && req_b) state_nxt = last ? OWN_A : OWN_B;
        else if (req_a)     state_nxt = OWN_A;
        else if (req_b)     state_nxt = OWN_B;
      end
      OWN_A: begin
        if (!req_a)                 state_nxt = req_b ? OWN_B : IDLE;
        else if (req_b && hold_hit) state_nxt = OWN_B;
      end
      OWN_B: begin
        if (!req_b)                 state_nxt = req_a ? OWN_A : IDLE;
        else if (req_a && hold_hit) state_nxt = OWN_A;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded straight from the state register, so they stay glitch-free.
  always_comb begin
    gnt_a  = (state == OWN_A);
    gnt_b  = (state == OWN_B);
    select = gnt_b;
  end

  assign mux_data = (a & ~{WIDTH{select}}) | (b & {WIDTH{select}});

  // Burst counter and round-robin pointer; both restart on each new ownership.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst <= 4'd0;
      last  <= 1'b1;
    end else if (enter_own) begin
      burst <= 4'd0;
      last  <= (state_nxt == OWN_B);
    end else if (xfer) begin
      burst <= burst_inc;
    end
  end

  // Output data register: loads only on a transfer, otherwise holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s       <= '0;
      s_valid <= 1'b0;
    end else begin
      s_valid <= xfer;
      if (xfer) s <= mux_data;
    end
  end

`ifdef MUX_RR_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_a <= 8'd0;
      cnt_b <= 8'd0;
    end else begin
      if (xfer_a && (cnt_a != 8'hFF)) cnt_a <= cnt_a + 8'd1;
      if (xfer_b && (cnt_b != 8'hFF)) cnt_b <= cnt_b + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (WIDTH=8, HOLD_MAX=4); the stats test is
// compiled in only when MUX_RR_ARBITER_STATS_EN is defined.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       reset_n;
  logic       req_a, req_b;
  logic [7:0] a, b;
  logic       gnt_a, gnt_b, select, s_valid;
  logic [7:0] s;
`ifdef MUX_RR_ARBITER_STATS_EN
  logic [7:0] cnt_a, cnt_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  mux_rr_arbiter #(.WIDTH(8), .HOLD_MAX(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req_a   (req_a),
    .req_b   (req_b),
    .a       (a),
    .b       (b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .select  (select),
    .s       (s),
    .s_valid (s_valid)
`ifdef MUX_RR_ARBITER_STATS_EN
    ,
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_a   = 1'b0;
    req_b   = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; a = 8'h00; b = 8'h00;
    #2;
    n_vec++; if ({gnt_a, gnt_b, select, s_valid} !== 4'b0000) begin n_err++; $display("FAIL reset_ctrl: got %b want 0000", {gnt_a, gnt_b, select, s_valid}); end
    n_vec++; if (s !== 8'h00) begin n_err++; $display("FAIL reset_s: got %h want 00", s); end
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    req_a = 1'b1; a = 8'h5A;
    step();
    n_vec++; if ({gnt_a, gnt_b} !== 2'b10) begin n_err++; $display("FAIL single_gnt: got %b want 10", {gnt_a, gnt_b}); end
    n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL single_valid0: got %b want 0", s_valid); end
    step();
    n_vec++; if (s !== 8'h5A) begin n_err++; $display("FAIL single_s: got %h want 5a", s); end
    n_vec++; if (s_valid !== 1'b1) begin n_err++; $display("FAIL single_valid1: got %b want 1", s_valid); end
    req_a = 1'b0;
    step();
    n_vec++; if ({gnt_a, gnt_b, s_valid} !== 3'b000) begin n_err++; $display("FAIL single_idle: got %b want 000", {gnt_a, gnt_b, s_valid}); end
    n_vec++; if (s !== 8'h5A) begin n_err++; $display("FAIL single_hold_s: got %h want 5a", s); end
  endtask

  // Tie after reset goes to A; A gets 4 transfers, then B takes over with no IDLE gap.
  task automatic test_hold();
    logic [7:0] exp_s;
    do_reset();
    req_a = 1'b1; req_b = 1'b1; a = 8'hA0; b = 8'hB5;
    for (int k = 1; k <= 5; k++) begin
      step();
      a = 8'hA0 | 8'(k);
      n_vec++; if ({gnt_a, gnt_b, select} !== ((k <= 4) ? 3'b100 : 3'b011)) begin n_err++; $display("FAIL hold_gnt[%0d]: got %b want %b", k, {gnt_a, gnt_b, select}, ((k <= 4) ? 3'b100 : 3'b011)); end
      n_vec++; if (s_valid !== (k >= 2)) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want %b", k, s_valid, (k >= 2)); end
      if (k >= 2) begin
        exp_s = 8'hA0 | 8'(k - 1);
        n_vec++; if (s !== exp_s) begin n_err++; $display("FAIL hold_s[%0d]: got %h want %h", k, s, exp_s); end
      end
    end
    step();
    n_vec++; if ({gnt_b, s_valid} !== 2'b11) begin n_err++; $display("FAIL hold_b_xfer: got %b want 11", {gnt_b, s_valid}); end
    n_vec++; if (s !== 8'hB5) begin n_err++; $display("FAIL hold_b_s: got %h want b5", s); end
  endtask

  // Owner B releases with A idle: back to IDLE, then A regrants after one edge.
  task automatic test_idle_regrant();
    req_a = 1'b0; req_b = 1'b0;
    step();
    n_vec++; if ({gnt_a, gnt_b, s_valid} !== 3'b000) begin n_err++; $display("FAIL idle_ctrl: got %b want 000", {gnt_a, gnt_b, s_valid}); end
    n_vec++; if (s !== 8'hB5) begin n_err++; $display("FAIL idle_s: got %h want b5", s); end
    req_a = 1'b1; a = 8'h3C;
    step();
    n_vec++; if ({gnt_a, gnt_b, s_valid} !== 3'b100) begin n_err++; $display("FAIL regrant: got %b want 100", {gnt_a, gnt_b, s_valid}); end
    step();
    n_vec++; if ({s, s_valid} !== {8'h3C, 1'b1}) begin n_err++; $display("FAIL regrant_s: got %h/%b want 3c/1", s, s_valid); end
  endtask

  // Lone owner keeps the grant; once saturated, a competing request switches on the next transfer.
  task automatic test_no_switch();
    int pulses;
    req_a = 1'b0;
    step();
    req_a = 1'b1; a = 8'h77;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_vec++; if ({gnt_a, gnt_b} !== 2'b10) begin n_err++; $display("FAIL lone_gnt[%0d]: got %b want 10", k, {gnt_a, gnt_b}); end
      if (s_valid === 1'b1) pulses++;
    end
    n_vec++; if (pulses != 19) begin n_err++; $display("FAIL lone_pulses: got %0d want 19", pulses); end
    req_b = 1'b1; b = 8'h99;
    step();
    n_vec++; if ({gnt_a, gnt_b, s_valid} !== 3'b011) begin n_err++; $display("FAIL sat_switch: got %b want 011", {gnt_a, gnt_b, s_valid}); end
    n_vec++; if (s !== 8'h77) begin n_err++; $display("FAIL sat_last_a: got %h want 77", s); end
    step();
    n_vec++; if (s !== 8'h99) begin n_err++; $display("FAIL sat_first_b: got %h want 99", s); end
  endtask

  // Async reset mid-burst in OWN_A (last = A); the next tie must still go to A.
  task automatic test_mid_reset();
    req_a = 1'b0; req_b = 1'b0;
    step();
    step();
    req_a = 1'b1; a = 8'h5A;
    step();
    step();
    #3 reset_n = 1'b0;
    #1;
    n_vec++; if ({gnt_a, gnt_b, select, s_valid} !== 4'b0000) begin n_err++; $display("FAIL midrst_ctrl: got %b want 0000", {gnt_a, gnt_b, select, s_valid}); end
    n_vec++; if (s !== 8'h00) begin n_err++; $display("FAIL midrst_s: got %h want 00", s); end
    #1 reset_n = 1'b1;
    req_b = 1'b1;
    step();
    n_vec++; if ({gnt_a, gnt_b, s_valid} !== 3'b100) begin n_err++; $display("FAIL midrst_tie: got %b want 100", {gnt_a, gnt_b, s_valid}); end
  endtask

`ifdef MUX_RR_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    req_a = 1'b1; a = 8'h11;
    for (int k = 0; k < 301; k++) step();
    req_a = 1'b0; req_b = 1'b1; b = 8'h22;
    for (int k = 0; k < 4; k++) step();
    req_b = 1'b0;
    n_vec++; if (cnt_a !== 8'd255) begin n_err++; $display("FAIL stats_a: got %0d want 255", cnt_a); end
    n_vec++; if (cnt_b !== 8'd3) begin n_err++; $display("FAIL stats_b: got %0d want 3", cnt_b); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_idle_regrant();
    test_no_switch();
    test_mid_reset();
`ifdef MUX_RR_ARBITER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the data width of each requester and of the output.
REQ-002 The block SHALL have parameter HOLD_MAX, default 4, legal range 1..15, the maximum consecutive grant cycles while the other side requests.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports req_a / req_b, input, 1 each, request from requester A / B.
REQ-006 The block SHALL have ports a / b, input, WIDTH each, data from requester A / B.
REQ-007 The block SHALL have ports gnt_a / gnt_b, output, 1 each, grant to A / B, registered, never both high.
REQ-008 The block SHALL have port select, output, 1, the mux select (0 = a, 1 = b), equal to gnt_b.
REQ-009 The block SHALL have port s, output, WIDTH, the registered selected data.
REQ-010 The block SHALL have port s_valid, output, 1, meaning s holds a word transferred in the previous cycle.

Function
REQ-011 The FSM SHALL have states IDLE, OWN_A and OWN_B; gnt_a = (OWN_A), gnt_b = (OWN_B).
REQ-012 A 1-bit round-robin pointer last SHALL record the most recent owner; a tie goes to the side that is not last.
REQ-013 From IDLE, the FSM SHALL go to OWN_A if only req_a is high, to OWN_B if only req_b is high, to the non-last side if both are high, and stay in IDLE otherwise.
REQ-014 Grant latency SHALL be exactly 1 cycle from req sampled high in IDLE to gnt high.
REQ-015 A transfer SHALL occur in any cycle where gnt_x and req_x are both high; the next edge loads s <= selected data and s_valid <= 1, otherwise s_valid <= 0 and s holds.
REQ-016 In OWN_x, a 4-bit burst counter SHALL increment on each transfer and saturate at HOLD_MAX.
REQ-017 In OWN_x, when req_x drops and the other side requests, the FSM SHALL switch directly to the other side's OWN state with no IDLE bubble.
REQ-018 In OWN_x, when req_x drops and the other side does not request, the FSM SHALL go to IDLE.
REQ-019 When the burst counter equals HOLD_MAX at a transfer and the other side requests, the FSM SHALL switch to the other side on the next edge, even if req_x stays high.
REQ-020 Without a competing request, the current owner SHALL keep the grant indefinitely; the counter stays saturated.
REQ-021 On every entry to an OWN state, the burst counter SHALL clear to 0 and last SHALL update to the new owner.
REQ-022 The selection SHALL be bitwise (a & ~select) | (b & select), matching the team's 2:1 gate mux.

Reset
REQ-023 Assertion of reset_n low SHALL immediately, without waiting for clk, force state = IDLE, last = B, burst counter = 0, gnt_a = gnt_b = select = 0, s = 0 and s_valid = 0.
REQ-024 Reset mid-burst SHALL drop the grant with no transfer; after release, arbitration restarts from IDLE with A winning the first tie.

Configuration
REQ-025 Macro MUX_RR_ARBITER_STATS_EN, when defined, SHALL add outputs cnt_a and cnt_b (8 bits each): saturating counts of transfers for A and B, reset to 0, saturating at 255.
REQ-026 Without MUX_RR_ARBITER_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-027 Reset, then req_a = 1, a = 8'h5A, req_b = 0 -> gnt_a = 1 after 1 edge; s = 8'h5A with s_valid = 1 after 2 edges.
REQ-028 Both requests raised together after reset -> A granted first (last = B); with HOLD_MAX = 4, A gets 4 transfers, then gnt_b = 1 with no IDLE cycle between.
REQ-029 In OWN_B, req_b drops and req_a = 0 -> IDLE with s_valid = 0; then req_a = 1 -> gnt_a one cycle later.
REQ-030 req_a held alone for 20 cycles -> gnt_a stays high throughout with 19 consecutive s_valid pulses and no switch.
REQ-031 reset_n pulsed low between clock edges mid-burst -> all outputs 0 before the next edge; the first tie after release goes to A.
REQ-032 With MUX_RR_ARBITER_STATS_EN defined, 300 A transfers and 3 B transfers -> cnt_a = 255, cnt_b = 3.
